// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader filling a DEPTH x 32 instruction memory, then releasing the core (optional checksum: IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
  parameter int i_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  logic [i_addr_bits-1:0] i_mem_addr,
  output logic [31:0]            i_mem_data,
  output logic                   cpu_rst_n,
  output logic                   load_done,
  output logic                   load_err
);
  localparam int AW = i_addr_bits - 2;
  localparam int DEPTH = 1 << AW;
  typedef enum logic [2:0] {
    COUNT,
    LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    RUN,
    ERROR
  } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t DONE = CHECK;
  logic [7:0] csum;
`else
  localparam state_t DONE = RUN;
`endif
  state_t state, state_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] word_cnt, last;
  logic [1:0] byte_idx;
  logic [23:0] partial;
  logic xfer, unused_addr;
  assign xfer = byte_valid & byte_ready;
  assign i_mem_data = mem[i_mem_addr[i_addr_bits-1:2]];
  assign load_done = cpu_rst_n;
  assign unused_addr = ^i_mem_addr[1:0];
  always_comb begin
    state_d = state;
    if (xfer)
      case (state)
        COUNT: state_d = byte_data == 8'd0 ? DONE : int'(byte_data) > DEPTH ? ERROR : LOAD;
        LOAD: state_d = byte_idx == 2'd3 && word_cnt == last ? DONE : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: state_d = byte_data == csum ? RUN : ERROR;
`endif
        default: state_d = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= COUNT;
      byte_ready <= 1'b0;
      cpu_rst_n <= 1'b0;
      load_err <= 1'b0;
      word_cnt <= '0;
      last <= '0;
      byte_idx <= '0;
      partial <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_d;
      byte_ready <= state_d != RUN && state_d != ERROR;
      cpu_rst_n <= state_d == RUN;
      load_err <= state_d == ERROR;
      if (xfer && state == COUNT) last <= AW'(byte_data - 8'd1);
      if (xfer && state == LOAD) begin
        byte_idx <= byte_idx + 2'd1;
        partial <= {byte_data, partial[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_data;
`endif
        if (byte_idx == 2'd3) begin
          mem[word_cnt] <= {byte_data, partial};
          if (word_cnt != last) word_cnt <= word_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready;
  logic [5:0] i_mem_addr = 6'd0;
  logic [31:0] i_mem_data;
  logic cpu_rst_n, load_done, load_err;
  int n_chk = 0;
  int n_fail = 0;
  imem_loader #(.i_addr_bits(6)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clk);
  endtask
  task automatic idle();
    byte_valid = 1'b0;
    byte_data = 8'hxx;
    @(negedge clk);
  endtask
  task automatic rd(input string tag, input logic [3:0] idx, input logic [1:0] off, input logic [31:0] exp);
    i_mem_addr = {idx, off};
    #1;
    chk(tag, i_mem_data, exp);
  endtask
  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    rd("rst_word0", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", byte_ready, 1);
    send(8'h02);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10);
    chk("b2b_before_last", cpu_rst_n, 0);
    chk("b2b_ready_in_load", byte_ready, 1);
    send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("b2b_check_wait", cpu_rst_n, 0);
    send(8'h90);
`endif
    idle();
    chk("b2b_cpu_rst_n", cpu_rst_n, 1);
    chk("b2b_load_done", load_done, 1);
    chk("b2b_load_err", load_err, 0);
    chk("b2b_ready_run", byte_ready, 0);
    rd("b2b_word0", 0, 0, 32'h0000_0013);
    rd("b2b_word1_addr4", 1, 0, 32'h0010_0093);
    rd("b2b_word1_lowbits", 1, 3, 32'h0010_0093);
    rd("b2b_word2_unwritten", 2, 0, 0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    idle();
    rd("run_ignores_word0", 0, 0, 32'h0000_0013);
    rd("run_ignores_word2", 2, 0, 0);
    chk("run_terminal", cpu_rst_n, 1);
    do_reset();
    send(8'h02); idle();
    send(8'h13); idle(); send(8'h00); idle(); send(8'h00); idle(); send(8'h00); idle();
    chk("tog_ready_idle", byte_ready, 1);
    send(8'h93); idle(); send(8'h00); idle(); send(8'h10); idle();
    chk("tog_before_last", cpu_rst_n, 0);
    send(8'h00); idle();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h90); idle();
`endif
    chk("tog_cpu_rst_n", cpu_rst_n, 1);
    rd("tog_word0", 0, 0, 32'h0000_0013);
    rd("tog_word1", 1, 0, 32'h0010_0093);
    rd("tog_word2", 2, 0, 0);
    do_reset();
    send(8'd17); idle();
    chk("n17_load_err", load_err, 1);
    chk("n17_cpu_rst_n", cpu_rst_n, 0);
    chk("n17_ready", byte_ready, 0);
    send(8'h55); send(8'h55); send(8'h55); send(8'h55); idle();
    rd("n17_word0", 0, 0, 0);
    chk("n17_terminal", load_err, 1);
    do_reset();
    send(8'd16); idle();
    chk("n16_load_err", load_err, 0);
    chk("n16_ready", byte_ready, 1);
    do_reset();
    send(8'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n0_check_wait", cpu_rst_n, 0);
    send(8'h00);
`endif
    idle();
    chk("n0_cpu_rst_n", cpu_rst_n, 1);
    chk("n0_load_err", load_err, 0);
    do_reset();
    send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    byte_valid = 1'b0;
    rd("mid_word0", 0, 0, 32'h4433_2211);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", byte_ready, 0);
    rd("mid_rst_word0", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h01); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    idle();
    chk("mid_new_cpu_rst_n", cpu_rst_n, 1);
    rd("mid_new_word0", 0, 0, 32'h1234_5678);
    rd("mid_new_word1", 1, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send(8'h01); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h09); idle();
    chk("csum_bad_err", load_err, 1);
    chk("csum_bad_cpu_rst_n", cpu_rst_n, 0);
    chk("csum_bad_ready", byte_ready, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
